window_sequencer: RTL and testbench
===================================

# window_sequencer

Controller for the shift-register line buffers that build a KxK convolution window over a raster-scanned image. It sits between the pixel source and the bank of `shift_reg` instances (line buffers plus window taps), and gates their shift enable. It tracks row/column position, clears the buffers at frame start, and flags when the buffer contents form a valid window. It applies backpressure to the source while the convolution stage has not consumed the current window.

## Interface
Parameters:
- `ImgWidth`, default 28: pixels per row.
- `ImgHeight`, default 28: rows per frame.
- `KernelSize`, default 3: window edge K. Requires 2 ≤ K ≤ min(`ImgWidth`, `ImgHeight`).

Ports:
- `clk_i`, in, 1: clock. Single clock domain.
- `rst_i`, in, 1: reset. Asynchronous, active-high.
- `start_i`, in, 1: begin a frame. Sampled only in IDLE.
- `pix_valid_i`, in, 1: the source presents a pixel.
- `pix_ready_o`, out, 1: the controller accepts a pixel this cycle.
- `shift_en_o`, out, 1: shift enable to every line-buffer `shift_reg`.
- `lb_clr_o`, out, 1: registered clear pulse to the line buffers' reset inputs.
- `win_valid_o`, out, 1: the buffer contents form a valid window.
- `win_ready_i`, in, 1: the consumer takes the window.
- `win_row_o`, out, $clog2(ImgHeight): top-left row of the current window.
- `win_col_o`, out, $clog2(ImgWidth): top-left column of the current window.
- `busy_o`, out, 1: a frame is in progress.
- `done_o`, out, 1: one-cycle pulse when the frame completes.

## Operation
- States:
  - IDLE: `start_i` → CLEAR.
  - CLEAR: one cycle, then RUN.
  - RUN: acceptance of pixel (H-1, W-1) → DRAIN.
  - DRAIN: handshake of the final window → DONE.
  - DONE: one cycle, then IDLE.
- Accept condition: accept = `pix_valid_i` & `pix_ready_o`.
- `pix_ready_o` = (state==RUN) & !(`win_valid_o` & !`win_ready_i`). A pending window blocks the next shift, because shifting would corrupt the window.
- `shift_en_o` = accept. It is combinational, so the shift happens on the same edge the pixel is accepted.
- Position counters `row`/`col` reset to 0 in CLEAR.
  - On accept, `col` increments.
  - When `col`==W-1, `col` wraps to 0 and `row` increments.
  - No wrap occurs at frame end; the FSM leaves RUN instead.
- Window rule: accepting a pixel at (r, c) with r ≥ K-1 and c ≥ K-1 sets `win_valid_o` on the next edge.
  - On that same edge, `win_row_o`/`win_col_o` load r-(K-1) and c-(K-1).
  - Pixels with c < K-1 (left edge, row wrap) produce no window.
- `win_valid_o` clears on `win_valid_o` & `win_ready_i`, unless it is set again on the same edge by a simultaneous accept. Set takes priority over clear.
- Windows per frame: (H-K+1)*(W-K+1). For the defaults this is 676.
- `lb_clr_o` is a flop, high exactly during CLEAR. `busy_o` is high in CLEAR, RUN and DRAIN.
- `start_i` outside IDLE is ignored. `win_ready_i` with no valid window is ignored.
- `rst_i` mid-frame returns the block to IDLE immediately. The line buffers are not cleared until the next CLEAR.

## Timing
- Reset values: state IDLE; every output 0, including `pix_ready_o` and `shift_en_o`, which are low because the state is not RUN.
- Frame start:
  - `start_i` high at edge 0 (in IDLE) → CLEAR after edge 0: `lb_clr_o`=1 and `busy_o`=1.
  - After edge 1: RUN, `pix_ready_o`=1 if no window is pending.
- Latency from accepting a window-completing pixel to `win_valid_o` is 1 cycle.
- Sustained throughput is one pixel per cycle when `win_ready_i` is held high.
- Frame end: `done_o` pulses in the cycle after the edge that handshakes the final window. `busy_o` falls in the same cycle `done_o` rises.

## Structure
- Package `window_seq_pkg`: the state enum (IDLE, CLEAR, RUN, DRAIN, DONE) and a function computing windows-per-frame from the parameters.
- One sub-module, `raster_counter`: the `col`/`row` counter pair with an increment enable, a synchronous clear and wrap flags.
- Counter widths: $clog2 of the dimension, with a minimum of 1.

## Test plan
- W=5, H=4, K=3, `pix_valid_i` and `win_ready_i` held high → 20 shifts and 6 windows. Windows appear at (row,col) (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). `done_o` pulses once; `busy_o` then falls.
- Same frame with `win_ready_i` low for 4 cycles after the first window → `pix_ready_o`=0 and `shift_en_o`=0 throughout. `win_row_o`/`win_col_o` hold at (0,0). Shifting resumes the cycle after `win_ready_i`=1.
- Random `pix_valid_i` gaps, ~50% duty → window count is still 6 and coordinates are unchanged. `shift_en_o` is never high without `pix_valid_i`.
- `start_i` pulsed in RUN → no state change and no `lb_clr_o`. `start_i` in IDLE → `lb_clr_o`=1 for exactly one cycle, then `pix_ready_o`=1.
- `rst_i` asserted after 7 pixels → all outputs 0 asynchronously. A new start then gives a full 6-window frame beginning at (0,0).
- Defaults (28x28, K=3), streaming → 784 shifts, 676 windows, last window at (25,25).

Source files
------------

// File: rtl/window_seq_pkg.sv
// Shared types and helpers for the convolution window sequencer.
package window_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Counter width for a dimension: $clog2(n), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 32'd1 : 32'($clog2(n));
  endfunction

  // Number of KxK windows produced by one WxH frame.
  function automatic int unsigned windows_per_frame(input int unsigned w,
                                                    input int unsigned h,
                                                    input int unsigned k);
    return (h - k + 1) * (w - k + 1);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row position counter for a raster scan; holds at the last pixel.
module raster_counter
  import window_seq_pkg::*;
#(
  parameter int unsigned Width  = 28,
  parameter int unsigned Height = 28
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         inc_i,
  output logic [cnt_width(Width)-1:0]  col_o,
  output logic [cnt_width(Height)-1:0] row_o,
  output logic                         col_wrap_c_o,
  output logic                         row_last_c_o
);

  localparam int unsigned ColW = cnt_width(Width);
  localparam int unsigned RowW = cnt_width(Height);

  logic [ColW-1:0] r_col;
  logic [RowW-1:0] r_row;

  assign col_wrap_c_o = (r_col == ColW'(Width - 1));
  assign row_last_c_o = (r_row == RowW'(Height - 1));
  assign col_o        = r_col;
  assign row_o        = r_row;

  // Advance column, wrap into next row; frame end leaves the position held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (clr_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (inc_i) begin
      if (col_wrap_c_o) begin
        if (!row_last_c_o) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/window_sequencer.sv
// Line-buffer controller: gates shifts, tracks position, flags KxK windows.
module window_sequencer
  import window_seq_pkg::*;
#(
  parameter int unsigned ImgWidth   = 28,
  parameter int unsigned ImgHeight  = 28,
  parameter int unsigned KernelSize = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic                            pix_valid_i,
  output logic                            pix_ready_o,
  output logic                            shift_en_o,
  output logic                            lb_clr_o,
  output logic                            win_valid_o,
  input  logic                            win_ready_i,
  output logic [cnt_width(ImgHeight)-1:0] win_row_o,
  output logic [cnt_width(ImgWidth)-1:0]  win_col_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int unsigned ColW = cnt_width(ImgWidth);
  localparam int unsigned RowW = cnt_width(ImgHeight);

  state_e          r_state;
  state_e          w_state_d;
  logic            w_pix_ready;
  logic            w_accept;
  logic            w_win_hs;
  logic            w_win_set;
  logic [ColW-1:0] w_col;
  logic [RowW-1:0] w_row;
  logic            w_col_wrap;
  logic            w_row_last;

  logic            r_lb_clr;
  logic            r_win_valid;
  logic [RowW-1:0] r_win_row;
  logic [ColW-1:0] r_win_col;
  logic            r_busy;
  logic            r_done;

  raster_counter #(
    .Width  (ImgWidth),
    .Height (ImgHeight)
  ) u_raster_counter (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (r_state == ST_CLEAR),
    .inc_i        (w_accept),
    .col_o        (w_col),
    .row_o        (w_row),
    .col_wrap_c_o (w_col_wrap),
    .row_last_c_o (w_row_last)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next state plus pixel/window handshake decode.
  always_comb begin
    w_state_d   = r_state;
    w_pix_ready = 1'b0;
    w_accept    = 1'b0;
    w_win_hs    = r_win_valid & win_ready_i;
    w_win_set   = 1'b0;
    // A pending window must not be disturbed by a shift.
    if (r_state == ST_RUN) begin
      w_pix_ready = !(r_win_valid && !win_ready_i);
    end
    w_accept  = pix_valid_i & w_pix_ready;
    w_win_set = w_accept && (w_row >= RowW'(KernelSize - 1))
                         && (w_col >= ColW'(KernelSize - 1));
    case (r_state)
      ST_IDLE:  if (start_i) w_state_d = ST_CLEAR;
      ST_CLEAR: w_state_d = ST_RUN;
      ST_RUN:   if (w_accept && w_col_wrap && w_row_last) w_state_d = ST_DRAIN;
      ST_DRAIN: if (w_win_hs) w_state_d = ST_DONE;
      ST_DONE:  w_state_d = ST_IDLE;
      default:  w_state_d = ST_IDLE;
    endcase
  end

  // Status outputs registered from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lb_clr <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_lb_clr <= (w_state_d == ST_CLEAR);
      r_busy   <= (w_state_d == ST_CLEAR) || (w_state_d == ST_RUN) ||
                  (w_state_d == ST_DRAIN);
      r_done   <= (w_state_d == ST_DONE);
    end
  end

  // Window flag and top-left coordinates; a new window beats a handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else if (w_win_set) begin
      r_win_valid <= 1'b1;
      r_win_row   <= w_row - RowW'(KernelSize - 1);
      r_win_col   <= w_col - ColW'(KernelSize - 1);
    end else if (w_win_hs) begin
      r_win_valid <= 1'b0;
    end
  end

  assign pix_ready_o = w_pix_ready;
  assign shift_en_o  = w_accept;
  assign lb_clr_o    = r_lb_clr;
  assign win_valid_o = r_win_valid;
  assign win_row_o   = r_win_row;
  assign win_col_o   = r_win_col;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule

// File: tb/tb_window_sequencer.sv
// Randomized bench for window_sequencer against a pixel-count reference model.
module tb_window_sequencer;

  localparam int W    = 5;
  localparam int H    = 4;
  localparam int K    = 3;
  localparam int NPIX = W * H;
  localparam int WPR  = W - K + 1;
  localparam int NWIN = (H - K + 1) * (W - K + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, pv_a, wr_a;
  logic       pr_a, se_a, clr_a, wv_a, busy_a, done_a;
  logic [1:0] row_a;
  logic [2:0] col_a;

  logic       start_b, pv_b, wr_b;
  logic       pr_b, se_b, clr_b, wv_b, busy_b, done_b;
  logic [4:0] row_b;
  logic [4:0] col_b;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 clear, 2 run, 3 drain, 4 done.
  int m_state, m_n, m_wv, m_wr, m_wc;

  window_sequencer #(.ImgWidth(W), .ImgHeight(H), .KernelSize(K)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .pix_valid_i(pv_a),
    .pix_ready_o(pr_a), .shift_en_o(se_a), .lb_clr_o(clr_a),
    .win_valid_o(wv_a), .win_ready_i(wr_a), .win_row_o(row_a),
    .win_col_o(col_a), .busy_o(busy_a), .done_o(done_a)
  );

  window_sequencer u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .pix_valid_i(pv_b),
    .pix_ready_o(pr_b), .shift_en_o(se_b), .lb_clr_o(clr_b),
    .win_valid_o(wv_b), .win_ready_i(wr_b), .win_row_o(row_b),
    .win_col_o(col_b), .busy_o(busy_b), .done_o(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_n = 0; m_wv = 0; m_wr = 0; m_wc = 0;
  endtask

  function automatic int model_ready(input logic wr);
    return ((m_state == 2) && !(m_wv != 0 && !wr)) ? 1 : 0;
  endfunction

  // One clock edge of the reference: pixel n sits at (n / W, n % W).
  task automatic model_edge(input logic st, input logic pv, input logic wr);
    int acc, hs, r, c, nst;
    acc = (pv && model_ready(wr) != 0) ? 1 : 0;
    hs  = (m_wv != 0 && wr) ? 1 : 0;
    nst = m_state;
    case (m_state)
      0: if (st) nst = 1;
      1: nst = 2;
      2: if (acc != 0 && m_n == NPIX - 1) nst = 3;
      3: if (hs != 0) nst = 4;
      default: nst = 0;
    endcase
    if (acc != 0) begin
      r = m_n / W;
      c = m_n % W;
      if (r >= K - 1 && c >= K - 1) begin
        m_wv = 1; m_wr = r - (K - 1); m_wc = c - (K - 1);
      end else if (hs != 0) begin
        m_wv = 0;
      end
      m_n++;
    end else if (hs != 0) begin
      m_wv = 0;
    end
    if (m_state == 1) m_n = 0;
    m_state = nst;
  endtask

  task automatic check_zero_a(input string nm);
    chk({nm, "/rst_ready"}, pr_a, 0);
    chk({nm, "/rst_shift"}, se_a, 0);
    chk({nm, "/rst_clr"},   clr_a, 0);
    chk({nm, "/rst_wv"},    wv_a, 0);
    chk({nm, "/rst_row"},   row_a, 0);
    chk({nm, "/rst_col"},   col_a, 0);
    chk({nm, "/rst_busy"},  busy_a, 0);
    chk({nm, "/rst_done"},  done_a, 0);
  endtask

  // mode 0 stream, 1 stall 4 cycles at first window, 2 pixel gaps + stray
  // starts, 3 random pixel and window handshakes. abort_at >= 0 resets mid-frame.
  task automatic run_frame(input int mode, input int abort_at, input string nm);
    int cyc = 0, shifts = 0, dones = 0, stall_left = 0;
    bit stalled = 0, fin = 0;
    int qr[$];
    int qc[$];
    while (!fin) begin
      start_a = (cyc == 0) ? 1'b1 : ((mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
      pv_a    = (mode >= 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 1 && !stalled && m_wv != 0) begin
        stalled = 1; stall_left = 4;
      end
      wr_a = (stall_left > 0) ? 1'b0 : ((mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1);
      if (stall_left > 0) stall_left--;
      @(negedge clk);
      chk({nm, "/pix_ready"}, pr_a, model_ready(wr_a));
      chk({nm, "/shift_en"},  se_a, (pv_a && model_ready(wr_a) != 0) ? 1 : 0);
      chk({nm, "/lb_clr"},    clr_a, (m_state == 1) ? 1 : 0);
      chk({nm, "/busy"},      busy_a, (m_state >= 1 && m_state <= 3) ? 1 : 0);
      chk({nm, "/done"},      done_a, (m_state == 4) ? 1 : 0);
      chk({nm, "/win_valid"}, wv_a, m_wv);
      chk({nm, "/win_row"},   row_a, m_wr);
      chk({nm, "/win_col"},   col_a, m_wc);
      if (se_a) shifts++;
      if (wv_a && wr_a) begin
        qr.push_back(int'(row_a));
        qc.push_back(int'(col_a));
      end
      if (done_a) dones++;
      if (abort_at >= 0 && m_state == 2 && m_n == abort_at) begin
        rst = 1'b1;
        #1;
        check_zero_a(nm);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      @(posedge clk);
      model_edge(start_a, pv_a, wr_a);
      #1;
      cyc++;
      if (m_state == 0) fin = 1;
      if (cyc > 400) begin
        chk({nm, "/timeout"}, 1, 0);
        fin = 1;
      end
    end
    start_a = 1'b0;
    @(negedge clk);
    chk({nm, "/busy_end"}, busy_a, 0);
    chk({nm, "/done_end"}, done_a, 0);
    chk({nm, "/shifts"}, shifts, NPIX);
    chk({nm, "/dones"}, dones, 1);
    chk({nm, "/windows"}, qr.size(), NWIN);
    for (int i = 0; i < qr.size() && i < NWIN; i++) begin
      chk({nm, "/wrow"}, qr[i], i / WPR);
      chk({nm, "/wcol"}, qc[i], i % WPR);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc, shifts, wins, lr, lc;
    bit seen_done;
    rst = 1'b1;
    start_a = 0; pv_a = 0; wr_a = 0;
    start_b = 0; pv_b = 0; wr_b = 0;
    model_reset();
    #3;
    check_zero_a("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    run_frame(0, -1, "stream");
    run_frame(1, -1, "stall");
    for (int i = 0; i < 3; i++) run_frame(2, -1, "gaps");
    run_frame(0, 7, "abort");
    run_frame(0, -1, "after_rst");
    for (int i = 0; i < 3; i++) run_frame(3, -1, "rand");

    // Default geometry, streaming with the consumer always ready.
    cyc = 0; shifts = 0; wins = 0; lr = -1; lc = -1; seen_done = 0;
    start_b = 1'b1; pv_b = 1'b1; wr_b = 1'b1;
    while (!seen_done && cyc < 2000) begin
      @(negedge clk);
      if (se_b) shifts++;
      if (wv_b) begin
        wins++; lr = int'(row_b); lc = int'(col_b);
      end
      if (done_b) begin
        seen_done = 1;
        chk("dflt/busy_at_done", busy_b, 0);
      end
      @(posedge clk);
      #1 start_b = 1'b0;
      cyc++;
    end
    chk("dflt/done_seen", seen_done, 1);
    chk("dflt/shifts", shifts, 784);
    chk("dflt/windows", wins, 676);
    chk("dflt/last_row", lr, 25);
    chk("dflt/last_col", lc, 25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
